multicycle_ctrl: RTL and testbench

Multi-cycle sequencing controller for the RV32I core. It steps each instruction through fetch, decode, execute, memory and write-back, and drives the enable and mux selects of the PC register, instruction register, register file, immediate/ALU operand muxes and data memory port. It sits beside the register-file/immediate decoder and reads the latched instruction word. It handles ready-based instruction and data memory handshakes, timeout faults, illegal opcodes and a run/halt request.

---
 rtl/multicycle_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// RV32I multi-cycle sequencer: walks each instruction through fetch, decode,
// execute, memory and write-back, driving datapath enables and mux selects.
module multicycle_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [31:0] inst,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        br_taken,
    output logic        imem_req,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic [1:0]  alu_a_sel,
    output logic        alu_b_sel,
    output logic [3:0]  alu_ctrl,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [1:0]  dmem_size,
    output logic        load_unsigned,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        retire,
    output logic        fault,
    output logic [2:0]  state
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_e;

    state_e        state_q, state_d, bound_st;
    logic [CW-1:0] cnt_q, cnt_d;

    logic is_r, is_i, is_ld, is_st, is_br;
    logic is_jal, is_jalr, is_lui, is_auipc, legal;
    logic [2:0] f3;
    logic       b30;
    logic       unused_inst;

    logic [1:0] a_dec;
    logic       b_dec;
    logic [3:0] alu_dec;

    assign f3       = inst[14:12];
    assign b30      = inst[30];
    assign is_r     = inst[6:0] == OP_R;
    assign is_i     = inst[6:0] == OP_I;
    assign is_ld    = inst[6:0] == OP_LD;
    assign is_st    = inst[6:0] == OP_ST;
    assign is_br    = inst[6:0] == OP_BR;
    assign is_jal   = inst[6:0] == OP_JAL;
    assign is_jalr  = inst[6:0] == OP_JALR;
    assign is_lui   = inst[6:0] == OP_LUI;
    assign is_auipc = inst[6:0] == OP_AUIPC;
    assign legal    = |{is_r, is_i, is_ld, is_st, is_br,
                        is_jal, is_jalr, is_lui, is_auipc};

    assign unused_inst = ^{inst[31], inst[29:15], inst[11:7]};
    assign bound_st    = run ? S_FETCH : S_IDLE;
    assign state       = state_q;

    // Operand/ALU selects depend only on the instruction; held EXEC..WB.
    always_comb begin
        a_dec   = 2'd0;
        b_dec   = 1'b0;
        alu_dec = ALU_ADD;
        unique case (1'b1)
            is_r, is_i: begin
                b_dec = is_i;
                unique case (f3)
                    3'd0: alu_dec = (is_r && b30) ? ALU_SUB : ALU_ADD;
                    3'd1: alu_dec = ALU_SLL;
                    3'd2: alu_dec = ALU_SLT;
                    3'd3: alu_dec = ALU_SLTU;
                    3'd4: alu_dec = ALU_XOR;
                    3'd5: alu_dec = b30 ? ALU_SRA : ALU_SRL;
                    3'd6: alu_dec = ALU_OR;
                    3'd7: alu_dec = ALU_AND;
                endcase
            end
            is_lui: begin
                a_dec = 2'd2;
                b_dec = 1'b1;
            end
            is_auipc, is_jal: begin
                a_dec = 2'd1;
                b_dec = 1'b1;
            end
            is_ld, is_st, is_jalr: b_dec = 1'b1;
            is_br:                 alu_dec = ALU_SUB;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = '0;
        imem_req      = 1'b0;
        ir_we         = 1'b0;
        pc_we         = 1'b0;
        pc_sel        = 2'd0;
        alu_a_sel     = 2'd0;
        alu_b_sel     = 1'b0;
        alu_ctrl      = ALU_ADD;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        dmem_size     = 2'd0;
        load_unsigned = 1'b0;
        reg_write     = 1'b0;
        wb_sel        = 2'd0;
        retire        = 1'b0;
        fault         = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (cnt_q == TMAX) begin
                    state_d = S_TRAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DECODE: begin
                state_d = legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                alu_a_sel = a_dec;
                alu_b_sel = b_dec;
                alu_ctrl  = alu_dec;
                if (is_br) begin
                    pc_we   = 1'b1;
                    pc_sel  = {1'b0, br_taken};
                    retire  = 1'b1;
                    state_d = bound_st;
                end else if (is_ld || is_st) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                alu_a_sel     = a_dec;
                alu_b_sel     = b_dec;
                alu_ctrl      = alu_dec;
                dmem_req      = 1'b1;
                dmem_we       = is_st;
                dmem_size     = inst[13:12];
                load_unsigned = inst[14];
                if (dmem_ready) begin
                    if (is_st) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = bound_st;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (cnt_q == TMAX) begin
                    state_d = S_TRAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WB: begin
                alu_a_sel     = a_dec;
                alu_b_sel     = b_dec;
                alu_ctrl      = alu_dec;
                dmem_size     = is_ld ? inst[13:12] : 2'd0;
                load_unsigned = is_ld & inst[14];
                reg_write     = 1'b1;
                wb_sel        = is_ld ? 2'd1 :
                                (is_jal || is_jalr) ? 2'd2 : 2'd0;
                pc_we         = 1'b1;
                pc_sel        = is_jal ? 2'd1 : is_jalr ? 2'd2 : 2'd0;
                retire        = 1'b1;
                state_d       = bound_st;
            end
            S_TRAP: begin
                fault = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed scenarios plus random back-to-back
// instructions checked against an instruction-level timing/select model.
module tb_multicycle_ctrl;

    localparam int TIMEOUT = 15;
    localparam int AMAP[8] = '{0, 2, 3, 4, 5, 6, 8, 9};

    logic        clk = 1'b0;
    logic        rst, run, imem_ready, dmem_ready, br_taken;
    logic [31:0] inst;
    logic        imem_req, ir_we, pc_we, alu_b_sel;
    logic [1:0]  pc_sel, alu_a_sel, dmem_size, wb_sel;
    logic [3:0]  alu_ctrl;
    logic        dmem_req, dmem_we, load_unsigned, reg_write;
    logic        retire, fault;
    logic [2:0]  state;
    logic [24:0] outs;

    multicycle_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .run(run), .inst(inst),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .br_taken(br_taken), .imem_req(imem_req), .ir_we(ir_we),
        .pc_we(pc_we), .pc_sel(pc_sel), .alu_a_sel(alu_a_sel),
        .alu_b_sel(alu_b_sel), .alu_ctrl(alu_ctrl),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_size(dmem_size), .load_unsigned(load_unsigned),
        .reg_write(reg_write), .wb_sel(wb_sel), .retire(retire),
        .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    assign outs = {imem_req, ir_we, pc_we, pc_sel, alu_a_sel, alu_b_sel,
                   alu_ctrl, dmem_req, dmem_we, dmem_size, load_unsigned,
                   reg_write, wb_sel, retire, fault, state};

    int n_vec = 0;
    int n_err = 0;

    int          o_ret, o_pcwe, o_mem, o_we, o_fetch;
    int          o_fault, o_pair, o_stray;
    logic [11:0] o_sig;
    logic [1:0]  o_dsz;
    logic        o_lu;
    logic [2:0]  o_st[$];

    typedef struct {
        int          ret;
        int          mem;
        int          we;
        logic [11:0] sig;
    } exp_t;

    // Instruction-level expectation: retire latency and the selects seen
    // in the retire cycle, derived from the instruction class alone.
    function automatic exp_t model(input logic [31:0] ins, input int iw,
                                   input int dw, input logic bt);
        exp_t e;
        int f3, alu;
        logic b30, b, rw;
        logic [1:0] pcsel, a, wb;
        e.ret = 0; e.mem = 0; e.we = 0;
        pcsel = 0; a = 0; b = 0; rw = 0; wb = 0; alu = 0;
        f3  = int'(ins[14:12]);
        b30 = ins[30];
        case (ins[6:0])
            7'b0110011: begin
                e.ret = 4 + iw; rw = 1; alu = AMAP[f3];
                if (f3 == 0 && b30) alu = 1;
                if (f3 == 5 && b30) alu = 7;
            end
            7'b0010011: begin
                e.ret = 4 + iw; rw = 1; b = 1; alu = AMAP[f3];
                if (f3 == 5 && b30) alu = 7;
            end
            7'b0000011: begin
                e.ret = 5 + iw + dw; e.mem = dw + 1;
                rw = 1; b = 1; wb = 1;
            end
            7'b0100011: begin
                e.ret = 4 + iw + dw; e.mem = dw + 1;
                e.we = dw + 1; b = 1;
            end
            7'b1100011: begin
                e.ret = 3 + iw; alu = 1; pcsel = bt ? 2'd1 : 2'd0;
            end
            7'b1101111: begin
                e.ret = 4 + iw; rw = 1; a = 1; b = 1; wb = 2; pcsel = 1;
            end
            7'b1100111: begin
                e.ret = 4 + iw; rw = 1; b = 1; wb = 2; pcsel = 2;
            end
            7'b0110111: begin
                e.ret = 4 + iw; rw = 1; a = 2; b = 1;
            end
            7'b0010111: begin
                e.ret = 4 + iw; rw = 1; a = 1; b = 1;
            end
            default: ;
        endcase
        e.sig = {pcsel, a, b, 4'(alu), rw, wb};
        return e;
    endfunction

    function automatic logic [31:0] rand_inst(input int cls);
        logic [31:0] r, res;
        logic [2:0] f3;
        logic [6:0] f7;
        r  = $urandom;
        f3 = 3'($urandom_range(0, 7));
        case (cls)
            0: begin
                f7 = ((f3 == 0 || f3 == 5) && r[30]) ? 7'h20 : 7'h00;
                res = {f7, r[24:15], f3, r[11:7], 7'b0110011};
            end
            1: begin
                f7 = (f3 == 1) ? 7'h00 :
                     (f3 == 5) ? {1'b0, r[30], 5'b0} : r[31:25];
                res = {f7, r[24:15], f3, r[11:7], 7'b0010011};
            end
            2: begin
                if (f3 == 3 || f3 == 6 || f3 == 7) f3 = 3'd2;
                res = {r[31:15], f3, r[11:7], 7'b0000011};
            end
            3: begin
                f3 = 3'($urandom_range(0, 2));
                res = {r[31:15], f3, r[11:7], 7'b0100011};
            end
            4: begin
                if (f3 == 2 || f3 == 3) f3 = 3'd0;
                res = {r[31:15], f3, r[11:7], 7'b1100011};
            end
            5: res = {r[31:7], 7'b1101111};
            6: res = {r[31:15], 3'b000, r[11:7], 7'b1100111};
            7: res = {r[31:7], 7'b0110111};
            default: res = {r[31:7], 7'b0010111};
        endcase
        return res;
    endfunction

    // Memory responder: drives one instruction from its first fetch cycle
    // until retire or fault, recording what the controller did.
    task automatic run_instr(input logic [31:0] ins, input int iw,
                             input int dw, input logic bt, input bit drop);
        int icnt = 0, dcnt = 0, cyc = 0;
        bit started = 0;
        inst = ins; br_taken = bt;
        o_ret = 0; o_pcwe = 0; o_mem = 0; o_we = 0; o_fetch = 0;
        o_fault = 0; o_pair = 0; o_stray = 0; o_sig = '0;
        o_dsz = '0; o_lu = 1'b0;
        o_st.delete();
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            imem_ready = 1'b0;
            dmem_ready = 1'b0;
            if (imem_req) started = 1;
            if (started) begin
                cyc++;
                if (imem_req) begin
                    o_fetch++;
                    imem_ready = (icnt == iw);
                    icnt++;
                end
                if (dmem_req) begin
                    o_mem++;
                    dmem_ready = (dcnt == dw);
                    dcnt++;
                    if (drop) run = 1'b0;
                end
                #1;
                o_st.push_back(state);
                if (dmem_req) begin
                    if (dmem_we) o_we++;
                    o_dsz = dmem_size;
                    o_lu  = load_unsigned;
                end
                if (pc_we) o_pcwe++;
                if (pc_we !== retire) o_pair++;
                if (reg_write && !retire) o_stray++;
                if (fault) begin
                    o_fault = cyc;
                    break;
                end
                if (retire) begin
                    o_ret = cyc;
                    o_sig = {pc_sel, alu_a_sel, alu_b_sel, alu_ctrl,
                             reg_write, wb_sel};
                    break;
                end
            end
        end
    endtask

    task automatic do_reset();
        run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b1; inst = 32'h00208033;
        imem_ready = 1'b1; dmem_ready = 1'b1; br_taken = 1'b1;
        #1 rst = 1'b0;
        #2;
        n_vec++;
        if (outs !== '0) begin
            n_err++;
            $display("FAIL reset_outs: got %h exp 0", outs);
        end
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if (state !== 3'd0) begin
            n_err++;
            $display("FAIL reset_hold: got %0d exp 0", state);
        end
        rst = 1'b1; run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        @(negedge clk);
        #1;
        n_vec++;
        if (state !== 3'd0 || imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL idle_norun: got %0d exp 0", state);
        end
    endtask

    task automatic test_add();
        exp_t e;
        e = model(32'h00208033, 0, 0, 1'b0);
        run = 1'b1;
        run_instr(32'h00208033, 0, 0, 1'b0, 1'b0);
        n_vec++;
        if (o_ret !== 4) begin
            n_err++;
            $display("FAIL add_ret: got %0d exp 4", o_ret);
        end
        n_vec++;
        if (o_st.size() != 4 || o_st[0] !== 3'd1 || o_st[1] !== 3'd2 ||
            o_st[2] !== 3'd3 || o_st[3] !== 3'd5) begin
            n_err++;
            $display("FAIL add_states: got %p exp 1,2,3,5", o_st);
        end
        n_vec++;
        if (o_sig !== e.sig || o_pcwe !== 1) begin
            n_err++;
            $display("FAIL add_sel: got %h/%0d exp %h/1",
                     o_sig, o_pcwe, e.sig);
        end
    endtask

    task automatic test_load();
        exp_t e;
        e = model(32'h0000A103, 0, 3, 1'b0);
        run_instr(32'h0000A103, 0, 3, 1'b0, 1'b0);
        n_vec++;
        if (o_ret !== 8 || o_ret !== e.ret) begin
            n_err++;
            $display("FAIL lw_ret: got %0d exp 8", o_ret);
        end
        n_vec++;
        if (o_mem !== 4 || o_we !== 0 || o_dsz !== 2'd2 || o_lu !== 1'b0) begin
            n_err++;
            $display("FAIL lw_mem: got %0d/%0d/%0d exp 4/0/2",
                     o_mem, o_we, o_dsz);
        end
        n_vec++;
        if (o_sig !== e.sig) begin
            n_err++;
            $display("FAIL lw_sel: got %h exp %h", o_sig, e.sig);
        end
    endtask

    task automatic test_branch();
        for (int t = 1; t >= 0; t--) begin
            exp_t e;
            e = model(32'hFE000EE3, 0, 0, 1'(t));
            run_instr(32'hFE000EE3, 0, 0, 1'(t), 1'b0);
            n_vec++;
            if (o_ret !== 3 || o_pcwe !== 1 || o_stray !== 0) begin
                n_err++;
                $display("FAIL beq%0d_ret: got %0d/%0d/%0d exp 3/1/0",
                         t, o_ret, o_pcwe, o_stray);
            end
            n_vec++;
            if (o_sig !== e.sig) begin
                n_err++;
                $display("FAIL beq%0d_sel: got %h exp %h", t, o_sig, e.sig);
            end
        end
    endtask

    task automatic test_wait_limit();
        run_instr(32'h00208033, TIMEOUT, 0, 1'b0, 1'b0);
        n_vec++;
        if (o_ret !== 4 + TIMEOUT || o_fault !== 0) begin
            n_err++;
            $display("FAIL imem_edge: got %0d exp %0d", o_ret, 4 + TIMEOUT);
        end
        run_instr(32'h00112023, 0, TIMEOUT, 1'b0, 1'b0);
        n_vec++;
        if (o_ret !== 4 + TIMEOUT || o_we !== TIMEOUT + 1) begin
            n_err++;
            $display("FAIL dmem_edge: got %0d exp %0d", o_ret, 4 + TIMEOUT);
        end
    endtask

    task automatic test_timeout();
        run_instr(32'h00208033, 1000, 0, 1'b0, 1'b0);
        n_vec++;
        if (o_fault !== TIMEOUT + 2 || o_fetch !== TIMEOUT + 1) begin
            n_err++;
            $display("FAIL imem_to: got %0d/%0d exp %0d/%0d",
                     o_fault, o_fetch, TIMEOUT + 2, TIMEOUT + 1);
        end
        #1 rst = 1'b0;
        #1;
        n_vec++;
        if (state !== 3'd0 || fault !== 1'b0 || outs !== '0) begin
            n_err++;
            $display("FAIL trap_rst: got %0d/%0d exp 0/0", state, fault);
        end
        do_reset();
        run = 1'b1;
        run_instr(32'h00112023, 0, 1000, 1'b0, 1'b0);
        n_vec++;
        if (o_fault !== TIMEOUT + 5 || o_mem !== TIMEOUT + 1) begin
            n_err++;
            $display("FAIL dmem_to: got %0d/%0d exp %0d/%0d",
                     o_fault, o_mem, TIMEOUT + 5, TIMEOUT + 1);
        end
        do_reset();
    endtask

    task automatic test_illegal();
        run = 1'b1;
        run_instr(32'h0000007F, 0, 0, 1'b0, 1'b0);
        n_vec++;
        if (o_fault !== 3 || o_pcwe !== 0) begin
            n_err++;
            $display("FAIL illegal: got %0d/%0d exp 3/0", o_fault, o_pcwe);
        end
        do_reset();
    endtask

    task automatic test_run_drop();
        run = 1'b1;
        run_instr(32'h00112023, 0, 2, 1'b0, 1'b1);
        n_vec++;
        if (o_ret !== 6 || o_pcwe !== 1) begin
            n_err++;
            $display("FAIL drop_ret: got %0d/%0d exp 6/1", o_ret, o_pcwe);
        end
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if (state !== 3'd0 || imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL drop_idle: got %0d exp 0", state);
        end
    endtask

    task automatic test_back_to_back();
        run = 1'b1;
        for (int i = 0; i < 60; i++) begin
            logic [31:0] ins;
            int iw, dw;
            logic bt;
            exp_t e;
            ins = rand_inst($urandom_range(0, 8));
            iw = ($urandom_range(0, 7) == 0) ? TIMEOUT : $urandom_range(0, 3);
            dw = ($urandom_range(0, 7) == 0) ? TIMEOUT : $urandom_range(0, 3);
            bt = 1'($urandom_range(0, 1));
            e = model(ins, iw, dw, bt);
            run_instr(ins, iw, dw, bt, 1'b0);
            n_vec++;
            if (o_ret !== e.ret) begin
                n_err++;
                $display("FAIL rnd%0d_ret %h: got %0d exp %0d",
                         i, ins, o_ret, e.ret);
            end
            n_vec++;
            if (o_sig !== e.sig) begin
                n_err++;
                $display("FAIL rnd%0d_sel %h: got %h exp %h",
                         i, ins, o_sig, e.sig);
            end
            n_vec++;
            if (o_mem !== e.mem || o_we !== e.we) begin
                n_err++;
                $display("FAIL rnd%0d_mem %h: got %0d/%0d exp %0d/%0d",
                         i, ins, o_mem, o_we, e.mem, e.we);
            end
            n_vec++;
            if (o_pcwe !== 1 || o_pair !== 0 || o_stray !== 0) begin
                n_err++;
                $display("FAIL rnd%0d_pulse %h: got %0d/%0d/%0d exp 1/0/0",
                         i, ins, o_pcwe, o_pair, o_stray);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_load();
        test_branch();
        test_wait_limit();
        test_timeout();
        test_illegal();
        test_run_drop();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1);
    end

endmodule
